// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219-style serial register receiver:
// register address map, FSM state encoding and small helpers.
package max7219_pkg;

    // Register address map (addr field is word bits [11:8]).
    localparam logic [3:0] ADDR_NOOP      = 4'h0;
    localparam logic [3:0] ADDR_DIG0      = 4'h1;
    localparam logic [3:0] ADDR_DIG1      = 4'h2;
    localparam logic [3:0] ADDR_DIG2      = 4'h3;
    localparam logic [3:0] ADDR_DIG3      = 4'h4;
    localparam logic [3:0] ADDR_DIG4      = 4'h5;
    localparam logic [3:0] ADDR_DIG5      = 4'h6;
    localparam logic [3:0] ADDR_DIG6      = 4'h7;
    localparam logic [3:0] ADDR_DIG7      = 4'h8;
    localparam logic [3:0] ADDR_DECODE    = 4'h9;
    localparam logic [3:0] ADDR_INTENSITY = 4'hA;
    localparam logic [3:0] ADDR_SCANLIM   = 4'hB;
    localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
    localparam logic [3:0] ADDR_TEST      = 4'hF;

    // Shift register and bit counter geometry.
    localparam int         SR_W      = 16;
    localparam int         CNT_W     = 5;
    localparam logic [4:0] CNT_MAX   = 5'd31;
    localparam logic [4:0] CNT_WORD  = 5'd16;

    // Receiver FSM encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_e;

    // Address of digit register idx (0..7).
    function automatic logic [3:0] digit_addr(input int idx);
        return ADDR_DIG0 + 4'(idx);
    endfunction

endpackage

// File: rtl/max7219_rx_sync_edge.sv
// Two-flop synchronizer for one asynchronous input, plus a third flop
// used only to derive single-cycle rise/fall pulses of the synchronized level.
module sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic async_sig,
    output logic sync_sig,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic s3;

    // Synchronizer chain; reset value chosen so reset release creates no edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1 <= RST_VAL;
            s2 <= RST_VAL;
            s3 <= RST_VAL;
        end else begin
            s1 <= async_sig;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign sync_sig = s2;
    assign rise     = s2 & ~s3;
    assign fall     = ~s2 & s3;

endmodule

// File: rtl/max7219_rx.sv
// Serial receiver for a MAX7219-style display driver bus. Frames are
// delimited by load (low during the word, rising edge latches it); bits are
// sampled on sck rises, MSB first. Accepted words write the addressed
// register; words shorter than 16 bits are rejected.
module max7219_rx
    import max7219_pkg::*;
#(
    parameter int MIN_HALF = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sck,
    input  logic        din,
    input  logic        load,
    output logic        dout,
    output logic [63:0] digits,
    output logic [7:0]  decode_mode,
    output logic [3:0]  intensity,
    output logic [2:0]  scan_limit,
    output logic        shutdown_n,
    output logic        test_mode,
    output logic        frame_valid,
    output logic [3:0]  frame_addr,
    output logic [7:0]  frame_data,
    output logic        frame_err,
    output state_e      fsm_state
);

    // Below two clocks per sck phase the synchronizer cannot resolve edges.
    if (MIN_HALF < 2) begin : g_min_half_check
        $error("max7219_rx: MIN_HALF must be at least 2");
    end

    logic sck_lvl, sck_rise, sck_fall;
    logic din_sync, din_rise, din_fall;
    logic load_lvl, load_rise, load_fall;

    sync_edge #(.RST_VAL(1'b0)) u_sync_sck (
        .clock(clock), .reset(reset), .async_sig(sck),
        .sync_sig(sck_lvl), .rise(sck_rise), .fall(sck_fall)
    );

    sync_edge #(.RST_VAL(1'b0)) u_sync_din (
        .clock(clock), .reset(reset), .async_sig(din),
        .sync_sig(din_sync), .rise(din_rise), .fall(din_fall)
    );

    sync_edge #(.RST_VAL(1'b1)) u_sync_load (
        .clock(clock), .reset(reset), .async_sig(load),
        .sync_sig(load_lvl), .rise(load_rise), .fall(load_fall)
    );

    // Only the levels/edges actually needed drive logic; the rest are parked.
    logic unused_sync;
    assign unused_sync = ^{sck_lvl, din_rise, din_fall, load_lvl};

    state_e            state;
    state_e            state_nx;
    logic [SR_W-1:0]   sr;
    logic [CNT_W-1:0]  cnt;
    logic              accept;
    logic              reject;
    logic [3:0]        word_addr;
    logic [7:0]        word_data;

    assign fsm_state = state;
    assign word_addr = sr[11:8];
    assign word_data = sr[7:0];
    assign accept    = (state == LATCH) && (cnt >= CNT_WORD);
    assign reject    = (state == LATCH) && (cnt <  CNT_WORD);

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next state: a load fall opens a frame, a load rise closes it,
    // and LATCH is a single evaluation cycle.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (load_fall) state_nx = SHIFT;
            SHIFT:   if (load_rise) state_nx = LATCH;
            LATCH:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Shift path: clear at frame start, shift on sck rise (a coincident load
    // rise takes priority and drops that bit), cascade MSB out on sck fall.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sr   <= '0;
            cnt  <= '0;
            dout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_fall) begin
                        sr  <= '0;
                        cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (sck_rise && !load_rise) begin
                        sr <= {sr[SR_W-2:0], din_sync};
                        if (cnt != CNT_MAX) begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                    if (sck_fall) begin
                        dout <= sr[SR_W-1];
                    end
                end
                default: ;
            endcase
        end
    end

    // Frame report: one-cycle status pulses; the last accepted word is held.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            frame_addr  <= '0;
            frame_data  <= '0;
        end else begin
            frame_valid <= accept;
            frame_err   <= reject;
            if (accept) begin
                frame_addr <= word_addr;
                frame_data <= word_data;
            end
        end
    end

    // Register file: written on the same edge that reports acceptance.
    // No-op and the unmapped addresses D/E fall through without a write.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            digits      <= '0;
            decode_mode <= '0;
            intensity   <= '0;
            scan_limit  <= '0;
            shutdown_n  <= 1'b0;
            test_mode   <= 1'b0;
        end else if (accept) begin
            for (int i = 0; i < 8; i++) begin
                if (word_addr == digit_addr(i)) begin
                    digits[8*i +: 8] <= word_data;
                end
            end
            case (word_addr)
                ADDR_DECODE:    decode_mode <= word_data;
                ADDR_INTENSITY: intensity   <= word_data[3:0];
                ADDR_SCANLIM:   scan_limit  <= word_data[2:0];
                ADDR_SHUTDOWN:  shutdown_n  <= word_data[0];
                ADDR_TEST:      test_mode   <= word_data[0];
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_max7219_rx.sv
// Bench for max7219_rx: drives serial frames on sck/din/load, predicts each
// frame outcome from the register map, and checks reported frames against
// a queue of expectations in a separate monitor.
`timescale 1ns/1ps
module tb_max7219_rx;
    import max7219_pkg::*;

    localparam int MIN_HALF = 2;

    // ---------------- clock / reset ----------------
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        sck   = 1'b0;
    logic        din   = 1'b0;
    logic        load  = 1'b1;
    logic        dout;
    logic [63:0] digits;
    logic [7:0]  decode_mode;
    logic [3:0]  intensity;
    logic [2:0]  scan_limit;
    logic        shutdown_n;
    logic        test_mode;
    logic        frame_valid;
    logic [3:0]  frame_addr;
    logic [7:0]  frame_data;
    logic        frame_err;
    state_e      fsm_state;

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    max7219_rx #(.MIN_HALF(MIN_HALF)) dut (
        .clock(clock), .reset(reset), .sck(sck), .din(din), .load(load),
        .dout(dout), .digits(digits), .decode_mode(decode_mode),
        .intensity(intensity), .scan_limit(scan_limit),
        .shutdown_n(shutdown_n), .test_mode(test_mode),
        .frame_valid(frame_valid), .frame_addr(frame_addr),
        .frame_data(frame_data), .frame_err(frame_err),
        .fsm_state(fsm_state)
    );

    // ---------------- scoreboard state ----------------
    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        bit          err;
        logic [3:0]  addr;
        logic [7:0]  data;
        logic [63:0] digits;
        logic [7:0]  dec;
        logic [3:0]  inten;
        logic [2:0]  scan;
        logic        shdn;
        logic        test;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];

    // Reference register image.
    logic [63:0] m_digits;
    logic [7:0]  m_dec;
    logic [3:0]  m_inten;
    logic [2:0]  m_scan;
    logic        m_shdn;
    logic        m_test;
    logic [3:0]  m_addr;
    logic [7:0]  m_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_digits = '0; m_dec = '0; m_inten = '0; m_scan = '0;
        m_shdn = 1'b0; m_test = 1'b0; m_addr = '0; m_data = '0;
    endtask

    // Frame of n bits = word[n-1:0], sent MSB first. Only the final 16 bits
    // matter; fewer than 16 is an error that leaves everything untouched.
    task automatic model_frame(input logic [31:0] word, input int n, input int load_cyc);
        exp_t e;
        logic [15:0] w;
        logic [3:0]  a;
        logic [7:0]  d;
        w = word[15:0];
        a = w[11:8];
        d = w[7:0];
        e.err = (n < 16);
        if (!e.err) begin
            m_addr = a;
            m_data = d;
            if (a >= 4'd1 && a <= 4'd8) m_digits[(int'(a) - 1) * 8 +: 8] = d;
            else if (a == 4'h9) m_dec   = d;
            else if (a == 4'hA) m_inten = d[3:0];
            else if (a == 4'hB) m_scan  = d[2:0];
            else if (a == 4'hC) m_shdn  = d[0];
            else if (a == 4'hF) m_test  = d[0];
        end
        e.addr = m_addr; e.data = m_data; e.digits = m_digits; e.dec = m_dec;
        e.inten = m_inten; e.scan = m_scan; e.shdn = m_shdn; e.test = m_test;
        e.cyc = load_cyc + 4;
        exp_q.push_back(e);
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_clk(input int k);
        repeat (k) @(posedge clock);
        #2;
    endtask

    // After k bits of this frame, the cascade MSB is the bit sent 16 earlier.
    task automatic check_dout(input logic [31:0] word, input int n, input int k);
        logic exp_bit;
        exp_bit = (k >= 16) ? word[n - 1 - (k - 16)] : 1'b0;
        chk($sformatf("dout_bit%0d", k), 64'(dout), 64'(exp_bit));
    endtask

    task automatic shift_bits(input logic [31:0] word, input int n, input int count);
        int lo, hi;
        for (int i = 0; i < count; i++) begin
            lo = int'($urandom_range(3, 5));
            hi = int'($urandom_range(MIN_HALF, MIN_HALF + 2));
            sck = 1'b0;
            din = word[n - 1 - i];
            wait_clk(lo);
            if (i > 0) check_dout(word, n, i);
            sck = 1'b1;
            wait_clk(hi);
        end
        sck = 1'b0;
        wait_clk(4);
    endtask

    task automatic send_frame(input logic [31:0] word, input int n);
        load = 1'b0;
        wait_clk(3);
        shift_bits(word, n, n);
        check_dout(word, n, n);
        model_frame(word, n, cyc);
        load = 1'b1;
        wait_clk(8);
    endtask

    task automatic check_reset_state();
        chk("rst_digits",      digits,            64'd0);
        chk("rst_decode_mode", 64'(decode_mode),  64'd0);
        chk("rst_intensity",   64'(intensity),    64'd0);
        chk("rst_scan_limit",  64'(scan_limit),   64'd0);
        chk("rst_shutdown_n",  64'(shutdown_n),   64'd0);
        chk("rst_test_mode",   64'(test_mode),    64'd0);
        chk("rst_dout",        64'(dout),         64'd0);
        chk("rst_frame_valid", 64'(frame_valid),  64'd0);
        chk("rst_frame_err",   64'(frame_err),    64'd0);
        chk("rst_frame_addr",  64'(frame_addr),   64'd0);
        chk("rst_frame_data",  64'(frame_data),   64'd0);
        chk("rst_fsm_state",   64'(fsm_state),    64'(IDLE));
    endtask

    // Start a frame, cut it with reset after 8 bits, then release cleanly.
    task automatic aborted_frame(input logic [31:0] word);
        load = 1'b0;
        wait_clk(3);
        shift_bits(word, 16, 8);
        reset = 1'b0;
        model_reset();
        load = 1'b1;
        din  = 1'b0;
        sck  = 1'b0;
        wait_clk(3);
        check_reset_state();
        reset = 1'b1;
        wait_clk(4);
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_digits"},      digits,            m_digits);
        chk({tag, "_decode_mode"}, 64'(decode_mode),  64'(m_dec));
        chk({tag, "_intensity"},   64'(intensity),    64'(m_inten));
        chk({tag, "_scan_limit"},  64'(scan_limit),   64'(m_scan));
        chk({tag, "_shutdown_n"},  64'(shutdown_n),   64'(m_shdn));
        chk({tag, "_test_mode"},   64'(test_mode),    64'(m_test));
        chk({tag, "_frame_addr"},  64'(frame_addr),   64'(m_addr));
        chk({tag, "_frame_data"},  64'(frame_data),   64'(m_data));
    endtask

    // ---------------- monitor ----------------
    exp_t mon_e;
    always @(negedge clock) begin
        if (reset && (frame_valid || frame_err)) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_frame: valid=%0b err=%0b with no frame pending (t=%0t)",
                         frame_valid, frame_err, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("frame_err",   64'(frame_err),   64'(mon_e.err));
                chk("frame_valid", 64'(frame_valid), 64'(!mon_e.err));
                chk("frame_addr",  64'(frame_addr),  64'(mon_e.addr));
                chk("frame_data",  64'(frame_data),  64'(mon_e.data));
                chk("digits",      digits,           mon_e.digits);
                chk("decode_mode", 64'(decode_mode), 64'(mon_e.dec));
                chk("intensity",   64'(intensity),   64'(mon_e.inten));
                chk("scan_limit",  64'(scan_limit),  64'(mon_e.scan));
                chk("shutdown_n",  64'(shutdown_n),  64'(mon_e.shdn));
                chk("test_mode",   64'(test_mode),   64'(mon_e.test));
                chk("frame_latency_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d frames pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    int          len_tab[9] = '{8, 12, 15, 16, 16, 16, 17, 20, 24};
    logic [31:0] dig_tab[8] = '{32'h0177, 32'h0230, 32'h0355, 32'h0402,
                                32'h05A5, 32'h0610, 32'h07C3, 32'h087E};

    initial begin
        model_reset();
        wait_clk(3);
        check_reset_state();
        reset = 1'b1;
        wait_clk(4);

        // Wake up: shutdown register.
        send_frame(32'h0C01, 16);
        check_regs("shutdown");

        // All eight digit registers.
        for (int i = 0; i < 8; i++) send_frame(dig_tab[i], 16);
        chk("digit0", 64'(digits[7:0]),   64'h77);
        chk("digit7", 64'(digits[63:56]), 64'h7E);

        // Short frame is rejected.
        send_frame(32'h0ABC, 12);
        check_regs("short");

        // Oversized frame keeps its final 16 bits.
        send_frame(32'hF0A0B, 20);
        chk("intensity_20bit", 64'(intensity), 64'hB);

        // Unmapped address and no-op.
        send_frame(32'h0D55, 16);
        send_frame(32'h0000, 16);
        check_regs("noop");

        // Reset mid-frame, then a clean frame.
        aborted_frame(32'h0B07);
        send_frame(32'h0B07, 16);
        chk("scan_limit_after_abort", 64'(scan_limit), 64'd7);

        // Randomized frames.
        for (int f = 0; f < 30; f++) begin
            send_frame($urandom, len_tab[$urandom_range(0, 8)]);
        end

        // Drain and final state.
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) wait_clk(1);
        chk("pending_frames", 64'(exp_q.size()), 64'd0);
        check_regs("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
